// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Shares one single-port scratch RAM between two requesters:
//   port 0 = core-side load/store path
//   port 1 = accelerator datapath
//
// Each accepted request runs a fixed four-cycle sequence:
//   IDLE (accept) -> ACCESS (RAM samples address/we) -> DATA (read data valid)
//   -> RESP (one-cycle response pulse) -> IDLE
//
// Configuration macro: RAM_ARB_ROUND_ROBIN_EN
//   defined   : round-robin between the ports on conflicts; port 0 wins first
//   undefined : fixed priority, port 0 always wins a conflict
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata      request from port N (held until reqN_ready)
//   reqN_ready                    combinational accept, only in IDLE
//   rspN_valid                    one-cycle completion pulse
//   rspN_rdata                    load data (0 for stores), held until next rsp
//   ram_write_enable/address/
//   ram_data_in                   registered RAM control pins
//   ram_data_out                  RAM read data, one cycle after address
module ram_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          ram_write_enable,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_t;

  state_t        state_reg, state_next;
  logic          grant_reg, grant_next;   // port owning the current transaction
  logic          txn_we_reg;              // store flag kept for the DATA capture
  logic          sel;                     // port the arbiter would pick now
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          ram_we_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [DW-1:0] ram_din_reg;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Resets to 1 so that port 0 wins the first conflict.
  logic last_grant_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      last_grant_reg <= sel;
    end
  end
`endif

  // Arbitration: a lone requester is always picked; on a conflict the
  // round-robin build picks the port not granted last.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      sel = ~last_grant_reg;
`else
      sel = 1'b0;
`endif
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign sel_we    = sel ? req1_we    : req0_we;
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;

  // Next-state and ready logic; ready exists only in IDLE.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~sel;
          req1_ready = sel;
          grant_next = sel;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = DATA;
      DATA:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= 1'b0;
      txn_we_reg   <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      // Write strobe is only ever high in the ACCESS cycle of a store.
      ram_we_reg <= accept & sel_we;
      // Address/data keep their values between transactions.
      if (accept) begin
        txn_we_reg   <= sel_we;
        ram_addr_reg <= sel_addr;
        ram_din_reg  <= sel_wdata;
      end
    end
  end

  assign ram_write_enable = ram_we_reg;
  assign ram_address      = ram_addr_reg;
  assign ram_data_in      = ram_din_reg;

  // Per-port response registers.
  logic [1:0]    rsp_valid_vec;
  logic [DW-1:0] rsp_rdata_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic          valid_reg;
      logic [DW-1:0] rdata_reg;
      logic          capture;

      assign capture = (state_reg == DATA) && (grant_reg == 1'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          rdata_reg <= '0;
        end else begin
          valid_reg <= capture;
          if (capture) begin
            rdata_reg <= txn_we_reg ? '0 : ram_data_out;
          end
        end
      end

      assign rsp_valid_vec[gi] = valid_reg;
      assign rsp_rdata_arr[gi] = rdata_reg;
    end
  endgenerate

  assign rsp0_valid = rsp_valid_vec[0];
  assign rsp1_valid = rsp_valid_vec[1];
  assign rsp0_rdata = rsp_rdata_arr[0];
  assign rsp1_rdata = rsp_rdata_arr[1];

endmodule
